// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between four requesters and the rr_arbiter4 round-robin arbiter.
// The master side drives requests; the slave side is the arbiter.
interface rr_arbiter4_if;
  logic [3:0] req;
  logic       any_req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;

  modport master (
    output req,
    input  any_req,
    input  gnt,
    input  gnt_valid,
    input  gnt_id
  );

  modport slave (
    input  req,
    output any_req,
    output gnt,
    output gnt_valid,
    output gnt_id
  );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with a registered one-hot grant.
// A contended owner is forced to rotate after MAX_HOLD consecutive cycles.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input logic          clk,
  input logic          rst,
  rr_arbiter4_if.slave bus
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic [1:0]        owner_r;
  logic [1:0]        next_owner_s;
  logic [1:0]        ptr_r;
  logic [1:0]        next_ptr_s;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [HOLD_W-1:0] next_hold_s;
  logic [3:0]        others_s;
  logic [1:0]        pick_ptr_s;
  logic [1:0]        pick_next_s;
  logic [3:0]        gnt_r;
  logic              gnt_valid_r;
  logic [1:0]        gnt_id_r;

  // First index with a request, scanning start, start+1, ... modulo 4.
  function automatic logic [1:0] pick(input logic [3:0] req_v, input logic [1:0] start);
    logic [1:0] sel;
    logic [1:0] idx;
    logic       found;
    sel   = start;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = start + 2'(i);
      if (!found && req_v[idx]) begin
        sel   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return sel;
  endfunction

  assign bus.any_req = |bus.req;
  assign others_s    = bus.req & ~(4'b0001 << owner_r);
  assign pick_ptr_s  = pick(bus.req, ptr_r);
  assign pick_next_s = pick(bus.req, owner_r + 2'd1);

  // Next-state, owner, pointer and hold-counter selection.
  always_comb begin
    next_state_s = state_r;
    next_owner_s = owner_r;
    next_ptr_s   = ptr_r;
    next_hold_s  = hold_cnt_r;
    case (state_r)
      IDLE: begin
        if (bus.any_req) begin
          next_state_s = GRANT;
          next_owner_s = pick_ptr_s;
          next_ptr_s   = pick_ptr_s + 2'd1;
          next_hold_s  = HOLD_ONE;
        end else begin
          next_state_s = IDLE;
        end
      end
      GRANT: begin
        if (!bus.req[owner_r]) begin
          if (|others_s) begin
            // Back-to-back handover, no idle cycle in between.
            next_owner_s = pick_next_s;
            next_ptr_s   = pick_next_s + 2'd1;
            next_hold_s  = HOLD_ONE;
          end else begin
            next_state_s = IDLE;
            next_hold_s  = HOLD_ZERO;
          end
        end else if ((hold_cnt_r == HOLD_MAX) && (|others_s)) begin
          next_owner_s = pick_next_s;
          next_ptr_s   = pick_next_s + 2'd1;
          next_hold_s  = HOLD_ONE;
        end else if (hold_cnt_r != HOLD_MAX) begin
          next_hold_s = hold_cnt_r + HOLD_ONE;
        end else begin
          next_hold_s = hold_cnt_r;
        end
      end
      default: begin
        next_state_s = IDLE;
        next_hold_s  = HOLD_ZERO;
      end
    endcase
  end

  // State and output registers; outputs are decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      owner_r     <= 2'd0;
      ptr_r       <= 2'd0;
      hold_cnt_r  <= HOLD_ZERO;
      gnt_r       <= 4'b0000;
      gnt_valid_r <= 1'b0;
      gnt_id_r    <= 2'd0;
    end else begin
      state_r    <= next_state_s;
      owner_r    <= next_owner_s;
      ptr_r      <= next_ptr_s;
      hold_cnt_r <= next_hold_s;
      if (next_state_s == GRANT) begin
        gnt_r       <= 4'b0001 << next_owner_s;
        gnt_valid_r <= 1'b1;
        gnt_id_r    <= next_owner_s;
      end else begin
        gnt_r       <= 4'b0000;
        gnt_valid_r <= 1'b0;
        gnt_id_r    <= 2'd0;
      end
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.gnt_valid = gnt_valid_r;
  assign bus.gnt_id    = gnt_id_r;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed-vector bench for rr_arbiter4 (MAX_HOLD = 8) with hand-computed expectations.
module tb_rr_arbiter4;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;

  rr_arbiter4_if bus_if ();

  rr_arbiter4 #(.MAX_HOLD(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_gnt(input string tag, input logic [3:0] g, input logic v, input logic [1:0] id);
    check({tag, "_gnt"}, 8'(bus_if.gnt), 8'(g));
    check({tag, "_valid"}, 8'(bus_if.gnt_valid), 8'(v));
    check({tag, "_id"}, 8'(bus_if.gnt_id), 8'(id));
  endtask

  initial begin
    logic [3:0] e;
    n_vec      = 0;
    n_miss     = 0;
    rst        = 1'b1;
    bus_if.req = 4'b1111;

    // Reset with all requests high
    tick();
    check_gnt("rst1", 4'b0000, 1'b0, 2'd0);
    check("any_req_in_rst", 8'(bus_if.any_req), 8'd1);
    tick();
    check_gnt("rst2", 4'b0000, 1'b0, 2'd0);
    rst = 1'b0;

    // Round robin, 8 cycles per owner, always one-hot
    for (int k = 0; k < 32; k++) begin
      tick();
      e = 4'b0001 << (k / 8);
      check("rr_gnt", 8'(bus_if.gnt), 8'(e));
      check("rr_onehot", 8'($onehot(bus_if.gnt)), 8'd1);
    end
    tick();
    check_gnt("rr_wrap", 4'b0001, 1'b1, 2'd0);

    // Voluntary release chain
    bus_if.req = 4'b1010;
    tick();
    check_gnt("rel_to1", 4'b0010, 1'b1, 2'd1);
    bus_if.req = 4'b1000;
    tick();
    check_gnt("rel_to3", 4'b1000, 1'b1, 2'd3);
    bus_if.req = 4'b0000;
    #1;
    check("any_req_zero", 8'(bus_if.any_req), 8'd0);
    tick();
    check_gnt("rel_idle", 4'b0000, 1'b0, 2'd0);

    // Pointer fairness: ptr=0 after owner 3, then ptr=1 after owner 0
    bus_if.req = 4'b0011;
    tick();
    check_gnt("ptr0", 4'b0001, 1'b1, 2'd0);
    bus_if.req = 4'b0000;
    tick();
    check_gnt("ptr0_idle", 4'b0000, 1'b0, 2'd0);
    bus_if.req = 4'b0011;
    tick();
    check_gnt("ptr1", 4'b0010, 1'b1, 2'd1);
    bus_if.req = 4'b0000;
    tick();
    check_gnt("ptr1_idle", 4'b0000, 1'b0, 2'd0);

    // Lone requester keeps the grant well past MAX_HOLD
    bus_if.req = 4'b0100;
    for (int k = 0; k < 20; k++) begin
      tick();
      check_gnt("single", 4'b0100, 1'b1, 2'd2);
    end
    bus_if.req = 4'b0000;
    tick();
    check_gnt("single_drop", 4'b0000, 1'b0, 2'd0);

    // Reset while owner 2 is at hold count 5
    bus_if.req = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      tick();
    end
    check_gnt("mid_pre", 4'b0100, 1'b1, 2'd2);
    rst = 1'b1;
    tick();
    check_gnt("mid_rst", 4'b0000, 1'b0, 2'd0);
    rst = 1'b0;
    tick();
    check_gnt("mid_regrant", 4'b0100, 1'b1, 2'd2);
    bus_if.req = 4'b0101;
    for (int k = 0; k < 7; k++) begin
      tick();
      check("mid_hold", 8'(bus_if.gnt), 8'(4'b0100));
    end
    tick();
    check_gnt("mid_rotate", 4'b0001, 1'b1, 2'd0);

    // Owner drops as another raises on the same edge
    bus_if.req = 4'b1000;
    tick();
    check_gnt("swap", 4'b1000, 1'b1, 2'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
